// File: rtl/strip_allocator_if.sv
// Bundle of signals between the strip allocator, the strip-ID ROM and the placement controller.
// The slave modport is the allocator; the master modport is the environment that also plays the ROM.
interface strip_allocator_if #(
    parameter int NUM_STRIPS = 13
);
    logic                  req_valid;
    logic [4:0]            req_height;
    logic                  req_ready;
    logic [3:0]            rom_addr;
    logic                  rom_en;
    logic [3:0]            rom_id1;
    logic [3:0]            rom_id2;
    logic [3:0]            rom_id3;
    logic                  grant_valid;
    logic                  grant_ok;
    logic [3:0]            grant_id;
    logic                  rel_valid;
    logic [3:0]            rel_id;
    logic [NUM_STRIPS-1:0] occupancy;
    logic [3:0]            free_count;

    modport master (
        output req_valid, req_height, rel_valid, rel_id, rom_id1, rom_id2, rom_id3,
        input  req_ready, rom_addr, rom_en, grant_valid, grant_ok, grant_id, occupancy, free_count
    );

    modport slave (
        input  req_valid, req_height, rel_valid, rel_id, rom_id1, rom_id2, rom_id3,
        output req_ready, rom_addr, rom_en, grant_valid, grant_ok, grant_id, occupancy, free_count
    );
endinterface

// File: rtl/strip_allocator.sv
// Maps a placement height to a strip-ID ROM address, grants the first free candidate strip
// from the ROM's three priority-ordered IDs, and tracks strip occupancy with releases.
module strip_allocator #(
    parameter int NUM_STRIPS = 13,
    parameter int H_MIN      = 4,
    parameter int H_MAX      = 16,
    parameter int H_SAT      = 13
) (
    input  logic               clk,
    input  logic               rst,
    strip_allocator_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK
    } state_t;

    localparam logic [4:0]            H_MIN_V   = 5'(H_MIN);
    localparam logic [4:0]            H_MAX_V   = 5'(H_MAX);
    localparam logic [4:0]            H_SAT_V   = 5'(H_SAT);
    localparam logic [3:0]            SAT_ADDR  = 4'(H_SAT - H_MIN);
    localparam logic [3:0]            ID_LIMIT  = 4'(NUM_STRIPS);
    localparam logic [3:0]            NO_ID     = 4'hD;
    localparam logic [3:0]            ALL_FREE  = 4'(NUM_STRIPS);
    localparam logic [NUM_STRIPS-1:0] ONE       = NUM_STRIPS'(1);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rom_en;
    logic [3:0]            r_rom_addr;
    logic                  r_grant_valid;
    logic                  r_grant_ok;
    logic [3:0]            r_grant_id;
    logic [NUM_STRIPS-1:0] r_occ;
    logic [3:0]            r_free_count;

    logic                  w_accept;
    logic                  w_height_legal;
    logic [3:0]            w_map_addr;
    logic [NUM_STRIPS-1:0] w_rel_mask;
    logic [NUM_STRIPS-1:0] w_eff_occ;
    logic                  w_sel_found;
    logic [3:0]            w_sel_id;
    logic [NUM_STRIPS-1:0] w_next_occ;
    logic [3:0]            w_next_free;

    function automatic logic cand_free(input logic [3:0] id, input logic [NUM_STRIPS-1:0] occ);
        return (id < ID_LIMIT) && ((occ & (ONE << id)) == '0);
    endfunction

    assign w_accept       = bus.req_valid && r_req_ready;
    assign w_height_legal = (bus.req_height >= H_MIN_V) && (bus.req_height <= H_MAX_V);
    assign w_map_addr     = (bus.req_height >= H_SAT_V) ? SAT_ADDR : 4'(bus.req_height - H_MIN_V);

    // A strip released on the allocation edge is already free for that allocation.
    assign w_rel_mask = (bus.rel_valid && (bus.rel_id < ID_LIMIT)) ? (ONE << bus.rel_id) : '0;
    assign w_eff_occ  = r_occ & ~w_rel_mask;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_sel_found = 1'b1;
        w_sel_id    = bus.rom_id1;
        if (cand_free(bus.rom_id1, w_eff_occ)) begin
            w_sel_id = bus.rom_id1;
        end else if (cand_free(bus.rom_id2, w_eff_occ)) begin
            w_sel_id = bus.rom_id2;
        end else if (cand_free(bus.rom_id3, w_eff_occ)) begin
            w_sel_id = bus.rom_id3;
        end else begin
            w_sel_found = 1'b0;
            w_sel_id    = NO_ID;
        end
    end

    always_comb begin
        w_next_occ = w_eff_occ;
        if ((r_state == S_CHECK) && w_sel_found) begin
            w_next_occ = w_eff_occ | (ONE << w_sel_id);
        end
    end

    // free_count is registered alongside occupancy so both change on the same edge.
    always_comb begin
        w_next_free = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            w_next_free = w_next_free + {3'b000, ~w_next_occ[i]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rom_en      <= 1'b0;
            r_rom_addr    <= '0;
            r_grant_valid <= 1'b0;
            r_grant_ok    <= 1'b0;
            r_grant_id    <= NO_ID;
            r_occ         <= '0;
            r_free_count  <= ALL_FREE;
        end else begin
            r_grant_valid <= 1'b0;
            r_occ         <= w_next_occ;
            r_free_count  <= w_next_free;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_height_legal) begin
                            r_rom_addr  <= w_map_addr;
                            r_rom_en    <= 1'b1;
                            r_req_ready <= 1'b0;
                            r_state     <= S_FETCH;
                        end else begin
                            r_grant_valid <= 1'b1;
                            r_grant_ok    <= 1'b0;
                            r_grant_id    <= NO_ID;
                        end
                    end
                end
                S_FETCH: begin
                    r_rom_en <= 1'b0;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    r_grant_valid <= 1'b1;
                    r_grant_ok    <= w_sel_found;
                    r_grant_id    <= w_sel_id;
                    r_req_ready   <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_rom_en    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rom_en      = r_rom_en;
    assign bus.rom_addr    = r_rom_addr;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_ok    = r_grant_ok;
    assign bus.grant_id    = r_grant_id;
    assign bus.occupancy   = r_occ;
    assign bus.free_count  = r_free_count;
endmodule

// File: tb/tb_strip_allocator.sv
// Self-checking bench for strip_allocator: a small ROM model plus an occupancy-map reference
// that applies the allocation and release rules directly on a bit vector.
module tb_strip_allocator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    logic [12:0] m_occ;
    logic [3:0]  rom_table [10][3];

    strip_allocator_if bus_if ();

    strip_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous strip-ID ROM: captures the address on an enabled edge.
    always @(posedge clk) begin
        if (rst) begin
            bus_if.rom_id1 <= 4'hF;
            bus_if.rom_id2 <= 4'hF;
            bus_if.rom_id3 <= 4'hF;
        end else if (bus_if.rom_en) begin
            if (bus_if.rom_addr < 4'd10) begin
                bus_if.rom_id1 <= rom_table[bus_if.rom_addr][0];
                bus_if.rom_id2 <= rom_table[bus_if.rom_addr][1];
                bus_if.rom_id3 <= rom_table[bus_if.rom_addr][2];
            end else begin
                bus_if.rom_id1 <= 4'hF;
                bus_if.rom_id2 <= 4'hF;
                bus_if.rom_id3 <= 4'hF;
            end
        end
    end

    function automatic logic [3:0] model_addr(input logic [4:0] h);
        int hv;
        hv = int'(h);
        return (hv >= 13) ? 4'd9 : 4'(hv - 4);
    endfunction

    function automatic int model_free();
        return 13 - $countones(m_occ);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.rel_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_occ = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_if.req_ready, bus_if.rom_en, bus_if.rom_addr} !== {1'b1, 1'b0, 4'd0}) begin
            n_mis++;
            $display("FAIL reset_ctrl: got ready/en/addr %b/%b/%0h, want 1/0/0",
                     bus_if.req_ready, bus_if.rom_en, bus_if.rom_addr);
        end
        n_cmp++;
        if ({bus_if.grant_valid, bus_if.grant_ok, bus_if.grant_id} !== {1'b0, 1'b0, 4'hD}) begin
            n_mis++;
            $display("FAIL reset_grant: got valid/ok/id %b/%b/%0h, want 0/0/d",
                     bus_if.grant_valid, bus_if.grant_ok, bus_if.grant_id);
        end
        n_cmp++;
        if ({bus_if.occupancy, bus_if.free_count} !== {13'h0000, 4'd13}) begin
            n_mis++;
            $display("FAIL reset_occ: got occ %h free %0d, want 0000 13",
                     bus_if.occupancy, bus_if.free_count);
        end
        rst = 1'b0;
        m_occ = '0;
    endtask

    // One request: model predicts grant, latency and ROM usage; optional release on the CHECK edge.
    task automatic issue(input logic [4:0] h, input bit rel_en, input logic [3:0] rid);
        bit         legal;
        bit         e_ok;
        logic [3:0] e_id;
        logic [3:0] addr;
        logic [3:0] c;
        int         e_lat;
        int         lat;
        int         rom_hi;
        bit         got;
        legal = (h >= 5'd4) && (h <= 5'd16);
        addr  = model_addr(h);
        e_ok  = 1'b0;
        e_id  = 4'hD;
        if (legal) begin
            if (rel_en && rid < 4'd13) m_occ[rid] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                c = rom_table[addr][k];
                if (!e_ok && c < 4'd13) begin
                    if (!m_occ[c]) begin
                        e_ok = 1'b1;
                        e_id = c;
                    end
                end
            end
            if (e_ok) m_occ[e_id] = 1'b1;
        end
        e_lat = legal ? 2 : 0;

        @(negedge clk);
        n_cmp++;
        if (bus_if.req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL req_ready_idle: got %b, want 1", bus_if.req_ready);
        end
        bus_if.req_valid  = 1'b1;
        bus_if.req_height = h;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        if (legal) begin
            n_cmp++;
            if (bus_if.rom_addr !== addr) begin
                n_mis++;
                $display("FAIL rom_addr h=%0d: got %0h, want %0h", h, bus_if.rom_addr, addr);
            end
        end
        lat    = 0;
        rom_hi = 0;
        got    = 1'b0;
        while (!got && lat <= 6) begin
            if (bus_if.rom_en === 1'b1) rom_hi++;
            if (bus_if.grant_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                bus_if.rel_valid = rel_en && (lat == 1);
                bus_if.rel_id    = rid;
                @(negedge clk);
                lat++;
            end
        end
        bus_if.rel_valid = 1'b0;

        n_cmp++;
        if (!got) begin
            n_mis++;
            $display("FAIL grant_timeout h=%0d: no grant_valid, want one after %0d cycles", h, e_lat);
        end else begin
            n_cmp++;
            if (lat != e_lat) begin
                n_mis++;
                $display("FAIL latency h=%0d: got %0d, want %0d", h, lat, e_lat);
            end
            n_cmp++;
            if (rom_hi != (legal ? 1 : 0)) begin
                n_mis++;
                $display("FAIL rom_en_cycles h=%0d: got %0d, want %0d", h, rom_hi, legal ? 1 : 0);
            end
            n_cmp++;
            if ({bus_if.grant_ok, bus_if.grant_id} !== {e_ok, e_id}) begin
                n_mis++;
                $display("FAIL grant h=%0d: got ok/id %b/%0h, want %b/%0h",
                         h, bus_if.grant_ok, bus_if.grant_id, e_ok, e_id);
            end
            n_cmp++;
            if ({bus_if.occupancy, bus_if.free_count} !== {m_occ, 4'(model_free())}) begin
                n_mis++;
                $display("FAIL occupancy h=%0d: got %h/%0d, want %h/%0d",
                         h, bus_if.occupancy, bus_if.free_count, m_occ, model_free());
            end
            @(negedge clk);
            n_cmp++;
            if ({bus_if.grant_valid, bus_if.rom_en, bus_if.req_ready} !== 3'b001) begin
                n_mis++;
                $display("FAIL post_grant h=%0d: got valid/en/ready %b%b%b, want 001",
                         h, bus_if.grant_valid, bus_if.rom_en, bus_if.req_ready);
            end
        end
    endtask

    task automatic release_strip(input logic [3:0] rid);
        @(negedge clk);
        bus_if.rel_valid = 1'b1;
        bus_if.rel_id    = rid;
        @(negedge clk);
        bus_if.rel_valid = 1'b0;
        if (rid < 4'd13) m_occ[rid] = 1'b0;
        n_cmp++;
        if ({bus_if.occupancy, bus_if.free_count} !== {m_occ, 4'(model_free())}) begin
            n_mis++;
            $display("FAIL release id=%0h: got %h/%0d, want %h/%0d",
                     rid, bus_if.occupancy, bus_if.free_count, m_occ, model_free());
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'd8, 1'b0, 4'd0);
        n_cmp++;
        if ({bus_if.occupancy, bus_if.free_count} !== {13'h0007, 4'd10}) begin
            n_mis++;
            $display("FAIL fill_final: got %h/%0d, want 0007/10", bus_if.occupancy, bus_if.free_count);
        end
    endtask

    task automatic test_priority();
        do_reset();
        issue(5'd8, 1'b0, 4'd0);
        issue(5'd8, 1'b0, 4'd0);
        issue(5'd7, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) issue(5'd4, 1'b0, 4'd0);
    endtask

    task automatic test_saturation();
        do_reset();
        issue(5'd13, 1'b0, 4'd0);
        issue(5'd16, 1'b0, 4'd0);
        issue(5'd3, 1'b0, 4'd0);
        issue(5'd17, 1'b0, 4'd0);
        issue(5'd0, 1'b0, 4'd0);
    endtask

    task automatic test_release();
        do_reset();
        for (int i = 0; i < 3; i++) issue(5'd8, 1'b0, 4'd0);
        issue(5'd8, 1'b1, 4'd1);
        n_cmp++;
        if (bus_if.occupancy !== 13'h0007) begin
            n_mis++;
            $display("FAIL release_regrant: got %h, want 0007", bus_if.occupancy);
        end
        release_strip(4'hE);
        release_strip(4'd5);
        release_strip(4'd2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(5'd8, 1'b0, 4'd0);
        issue(5'd8, 1'b0, 4'd0);
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_height = 5'd8;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_occ = '0;
        n_cmp++;
        if ({bus_if.req_ready, bus_if.grant_valid, bus_if.occupancy, bus_if.free_count}
            !== {1'b1, 1'b0, 13'h0000, 4'd13}) begin
            n_mis++;
            $display("FAIL reset_mid: got ready/gv/occ/free %b/%b/%h/%0d, want 1/0/0000/13",
                     bus_if.req_ready, bus_if.grant_valid, bus_if.occupancy, bus_if.free_count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_if.grant_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL reset_mid_no_grant cycle %0d: got %b, want 0", i, bus_if.grant_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] h;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            h = 5'($urandom_range(31, 0));
            issue(h, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
            if ($urandom_range(2, 0) == 0) release_strip(4'($urandom_range(15, 0)));
        end
    endtask

    // req_valid held high: the model expects acceptance every third edge, grant two edges later.
    task automatic test_back_to_back();
        int         n_req;
        int         n_grant;
        logic [4:0] h_cur;
        logic [3:0] c;
        logic [3:0] e_id;
        bit         e_ok;
        bit         rv;
        logic [3:0] rid;
        do_reset();
        n_req   = 0;
        n_grant = 0;
        h_cur   = 5'd4;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        for (int k = 0; k < 90; k++) begin
            if (k % 3 == 0) begin
                h_cur = 5'($urandom_range(16, 4));
                bus_if.req_height = h_cur;
                n_req++;
            end
            n_cmp++;
            if (bus_if.req_ready !== ((k % 3) == 0)) begin
                n_mis++;
                $display("FAIL b2b_ready k=%0d: got %b, want %b", k, bus_if.req_ready, (k % 3) == 0);
            end
            rv  = ($urandom_range(3, 0) == 0);
            rid = 4'($urandom_range(15, 0));
            bus_if.rel_valid = rv;
            bus_if.rel_id    = rid;
            if (rv && rid < 4'd13) m_occ[rid] = 1'b0;
            e_ok = 1'b0;
            e_id = 4'hD;
            if (k % 3 == 2) begin
                for (int j = 0; j < 3; j++) begin
                    c = rom_table[model_addr(h_cur)][j];
                    if (!e_ok && c < 4'd13) begin
                        if (!m_occ[c]) begin
                            e_ok = 1'b1;
                            e_id = c;
                        end
                    end
                end
                if (e_ok) m_occ[e_id] = 1'b1;
            end
            @(negedge clk);
            n_cmp++;
            if (bus_if.grant_valid !== ((k % 3) == 2)) begin
                n_mis++;
                $display("FAIL b2b_gv k=%0d: got %b, want %b", k, bus_if.grant_valid, (k % 3) == 2);
            end
            if (k % 3 == 2) begin
                if (bus_if.grant_valid === 1'b1) n_grant++;
                n_cmp++;
                if ({bus_if.grant_ok, bus_if.grant_id} !== {e_ok, e_id}) begin
                    n_mis++;
                    $display("FAIL b2b_grant k=%0d h=%0d: got %b/%0h, want %b/%0h",
                             k, h_cur, bus_if.grant_ok, bus_if.grant_id, e_ok, e_id);
                end
            end
            n_cmp++;
            if ({bus_if.occupancy, bus_if.free_count} !== {m_occ, 4'(model_free())}) begin
                n_mis++;
                $display("FAIL b2b_occ k=%0d: got %h/%0d, want %h/%0d",
                         k, bus_if.occupancy, bus_if.free_count, m_occ, model_free());
            end
        end
        bus_if.req_valid = 1'b0;
        bus_if.rel_valid = 1'b0;
        n_cmp++;
        if (n_grant != n_req) begin
            n_mis++;
            $display("FAIL b2b_count: got %0d grants, want %0d", n_grant, n_req);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_occ = '0;
        rst   = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_height = '0;
        bus_if.rel_valid  = 1'b0;
        bus_if.rel_id     = '0;
        rom_table[0] = '{4'h9, 4'h7, 4'hD};
        rom_table[1] = '{4'h5, 4'h6, 4'hE};
        rom_table[2] = '{4'h8, 4'h4, 4'hF};
        rom_table[3] = '{4'h3, 4'h0, 4'h1};
        rom_table[4] = '{4'h0, 4'h1, 4'h2};
        rom_table[5] = '{4'hB, 4'hC, 4'hA};
        rom_table[6] = '{4'h2, 4'hD, 4'h6};
        rom_table[7] = '{4'h4, 4'h4, 4'h5};
        rom_table[8] = '{4'hF, 4'hE, 4'hC};
        rom_table[9] = '{4'hA, 4'hB, 4'hC};
        test_reset();
        test_fill();
        test_priority();
        test_saturation();
        test_release();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
